// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte-lane selection, store positioning and load extension over a req/ack word port.
// Optional LSU_MISALIGNED_EN splits word-spanning accesses into two word transfers; otherwise they fault.
module load_store_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic                  WE,
  input  logic [2:0]            Type,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [31:0]           WriteData,
  output logic [31:0]           ReadData,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Fault,
  output logic                  MemReq,
  output logic                  MemWE,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [3:0]            MemBE,
  output logic [31:0]           MemWData,
  input  logic [31:0]           MemRData,
  input  logic                  MemAck
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
`ifdef LSU_MISALIGNED_EN
    ACC1 = 2'd3,
`endif
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  // Size mask shifted by the byte offset; bits [7:4] are the lanes that spill into the next word.
  function automatic logic [7:0] lane_mask(input logic [2:0] typ, input logic [1:0] off);
    logic [7:0] m;
    case (typ[1:0])
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      default: m = 8'h0F;
    endcase
    return m << off;
  endfunction

  function automatic logic type_legal(input logic we, input logic [2:0] typ);
    if (we) return typ inside {3'b000, 3'b001, 3'b010};
    return typ inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] a, input logic [2:0] typ);
    case (typ)
      3'b000:  return {{24{a[7]}}, a[7:0]};
      3'b001:  return {{16{a[15]}}, a[15:0]};
      3'b100:  return {24'b0, a[7:0]};
      3'b101:  return {16'b0, a[15:0]};
      default: return a;
    endcase
  endfunction

  state_t                  state_q, state_d;
  logic                    we_q;
  logic [2:0]              type_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic                    fault_q, fault_d;
  logic [31:0]             asm_q, asm_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [7:0]              cnt_q, cnt_d;

  logic                    start_reject;
  logic [ADDR_WIDTH-1:0]   base_addr;
  logic [3:0]              be0;
  logic [5:0]              sh_lo;

  assign base_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign be0       = 4'(lane_mask(type_q, addr_q[1:0]));
  assign sh_lo     = {1'b0, addr_q[1:0], 3'b000};
  assign ReadData  = rdata_q;

`ifdef LSU_MISALIGNED_EN
  logic       split_q;
  logic [3:0] be1;
  logic [5:0] sh_hi;
  assign split_q      = |be1;
  assign be1          = 4'(lane_mask(type_q, addr_q[1:0]) >> 4);
  assign sh_hi        = 6'd32 - sh_lo;
  assign start_reject = !type_legal(WE, Type);
`else
  logic start_split;
  assign start_split  = |(lane_mask(Type, Addr[1:0]) >> 4);
  assign start_reject = !type_legal(WE, Type) || start_split;
`endif

  always_comb begin
    state_d  = state_q;
    fault_d  = fault_q;
    asm_d    = asm_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    Busy     = (state_q != IDLE);
    Done     = 1'b0;
    Fault    = 1'b0;
    MemReq   = 1'b0;
    MemWE    = 1'b0;
    MemAddr  = '0;
    MemBE    = 4'b0;
    MemWData = 32'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          cnt_d   = 8'd0;
          fault_d = start_reject;
          state_d = start_reject ? DONE : ACC0;
        end
      end
      ACC0: begin
        MemReq   = 1'b1;
        MemWE    = we_q;
        MemAddr  = base_addr;
        MemBE    = be0;
        MemWData = wdata_q << sh_lo;
        if (MemAck) begin
          asm_d = (MemRData & byte_mask(be0)) >> sh_lo;
`ifdef LSU_MISALIGNED_EN
          if (split_q) begin
            cnt_d   = 8'd0;
            state_d = ACC1;
          end else begin
            state_d = DONE;
            if (!we_q) rdata_d = extend(asm_d, type_q);
          end
`else
          state_d = DONE;
          if (!we_q) rdata_d = extend(asm_d, type_q);
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TO_LIMIT) begin
            fault_d = 1'b1;
            state_d = DONE;
          end
        end
      end
`ifdef LSU_MISALIGNED_EN
      ACC1: begin
        MemReq   = 1'b1;
        MemWE    = we_q;
        MemAddr  = base_addr + ADDR_WIDTH'(4);
        MemBE    = be1;
        MemWData = wdata_q >> sh_hi;
        if (MemAck) begin
          // Spilled bytes follow the bytes already gathered from the first word.
          asm_d   = asm_q | ((MemRData & byte_mask(be1)) << sh_hi);
          state_d = DONE;
          if (!we_q) rdata_d = extend(asm_d, type_q);
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TO_LIMIT) begin
            fault_d = 1'b1;
            state_d = DONE;
          end
        end
      end
`endif
      DONE: begin
        Done    = 1'b1;
        Fault   = fault_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      type_q  <= 3'b0;
      addr_q  <= '0;
      wdata_q <= 32'b0;
      fault_q <= 1'b0;
      asm_q   <= 32'b0;
      rdata_q <= 32'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      asm_q   <= asm_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && Start) begin
        we_q    <= WE;
        type_q  <= Type;
        addr_q  <= Addr;
        wdata_q <= WriteData;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; inputs driven and outputs checked on the falling edge.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic        WE;
  logic [2:0]  Type;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Busy;
  logic        Done;
  logic        Fault;
  logic        MemReq;
  logic        MemWE;
  logic [31:0] MemAddr;
  logic [3:0]  MemBE;
  logic [31:0] MemWData;
  logic [31:0] MemRData;
  logic        MemAck;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .Start(Start), .WE(WE), .Type(Type), .Addr(Addr),
    .WriteData(WriteData), .ReadData(ReadData), .Busy(Busy), .Done(Done),
    .Fault(Fault), .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr),
    .MemBE(MemBE), .MemWData(MemWData), .MemRData(MemRData), .MemAck(MemAck)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a request for one cycle; returns in cycle 1 of the access.
  task automatic issue(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                       input logic [31:0] wdata);
    Start = 1'b1; WE = we; Type = typ; Addr = addr; WriteData = wdata;
    tick();
    Start = 1'b0;
  endtask

  task automatic ack_with(input logic [31:0] data);
    MemAck = 1'b1; MemRData = data;
    tick();
    MemAck = 1'b0; MemRData = 32'h0;
  endtask

  initial begin
    rst = 1'b1; Start = 1'b0; WE = 1'b0; Type = 3'b0; Addr = 32'h0;
    WriteData = 32'h0; MemRData = 32'h0; MemAck = 1'b0;
    tick(); tick();
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_fault", Fault, 0);
    check("rst_memreq", MemReq, 0);
    check("rst_memwe", MemWE, 0);
    check("rst_memaddr", MemAddr, 0);
    check("rst_membe", MemBE, 0);
    check("rst_readdata", ReadData, 0);
    rst = 1'b0;
    tick();

    // LW, zero wait
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    check("lw_req", MemReq, 1);
    check("lw_busy", Busy, 1);
    check("lw_addr", MemAddr, 32'h100);
    check("lw_be", MemBE, 4'b1111);
    check("lw_we", MemWE, 0);
    check("lw_done_c1", Done, 0);
    ack_with(32'hDEADBEEF);
    check("lw_done", Done, 1);
    check("lw_fault", Fault, 0);
    check("lw_rdata", ReadData, 32'hDEADBEEF);
    check("lw_req_c2", MemReq, 0);
    tick();
    check("lw_idle_busy", Busy, 0);
    check("lw_idle_done", Done, 0);

    // LB / LBU at the top byte
    issue(1'b0, 3'b000, 32'h103, 32'h0);
    check("lb_addr", MemAddr, 32'h100);
    check("lb_be", MemBE, 4'b1000);
    ack_with(32'h80000000);
    check("lb_done", Done, 1);
    check("lb_rdata", ReadData, 32'hFFFFFF80);
    tick();
    issue(1'b0, 3'b100, 32'h103, 32'h0);
    ack_with(32'h80000000);
    check("lbu_done", Done, 1);
    check("lbu_rdata", ReadData, 32'h00000080);
    tick();

    // SW spanning two words
    issue(1'b1, 3'b010, 32'h202, 32'h11223344);
`ifdef LSU_MISALIGNED_EN
    check("sw0_req", MemReq, 1);
    check("sw0_we", MemWE, 1);
    check("sw0_addr", MemAddr, 32'h200);
    check("sw0_be", MemBE, 4'b1100);
    check("sw0_wdata", MemWData, 32'h33440000);
    ack_with(32'h0);
    check("sw1_req", MemReq, 1);
    check("sw1_addr", MemAddr, 32'h204);
    check("sw1_be", MemBE, 4'b0011);
    check("sw1_wdata", MemWData, 32'h00001122);
    check("sw1_done", Done, 0);
    ack_with(32'h0);
    check("sw_done", Done, 1);
    check("sw_fault", Fault, 0);
    check("sw_rdata", ReadData, 32'h00000080);
    tick();
    check("sw_single_done", Done, 0);
`else
    check("sw_rej_done", Done, 1);
    check("sw_rej_fault", Fault, 1);
    check("sw_rej_req", MemReq, 0);
    tick();
    check("sw_rej_busy", Busy, 0);
    check("sw_rej_req2", MemReq, 0);
`endif

    // Illegal load type
    issue(1'b0, 3'b011, 32'h100, 32'h0);
    check("ill_done", Done, 1);
    check("ill_fault", Fault, 1);
    check("ill_req", MemReq, 0);
    check("ill_rdata", ReadData, 32'h00000080);
    tick();
    check("ill_busy", Busy, 0);

    // Timeout with MemAck held low; a Start while busy is ignored
    issue(1'b0, 3'b010, 32'h300, 32'h0);
    check("to_req_c1", MemReq, 1);
    tick();
    check("to_req_c2", MemReq, 1);
    Start = 1'b1; WE = 1'b1; Type = 3'b010; Addr = 32'h500;
    tick();
    Start = 1'b0;
    check("to_req_c3", MemReq, 1);
    check("to_addr_c3", MemAddr, 32'h300);
    tick();
    check("to_req_c4", MemReq, 1);
    tick();
    check("to_done", Done, 1);
    check("to_fault", Fault, 1);
    check("to_req_c5", MemReq, 0);
    check("to_rdata", ReadData, 32'h00000080);
    tick();
    check("to_busy_c6", Busy, 0);
    MemAck = 1'b1; MemRData = 32'h12345678;
    tick();
    MemAck = 1'b0; MemRData = 32'h0;
    check("to_noqueue_req", MemReq, 0);
    check("to_noqueue_done", Done, 0);
    check("to_stray_ack_rdata", ReadData, 32'h00000080);

    // Reset in the middle of a waiting LW
    issue(1'b0, 3'b010, 32'h400, 32'h0);
    check("rmid_req_c1", MemReq, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rmid_req", MemReq, 0);
    check("rmid_done", Done, 0);
    check("rmid_busy", Busy, 0);
    check("rmid_rdata", ReadData, 0);
    tick();
    check("rmid_done2", Done, 0);

    // LH upper half with one wait cycle
    issue(1'b0, 3'b001, 32'h102, 32'h0);
    check("lh_be", MemBE, 4'b1100);
    tick();
    check("lh_wait_req", MemReq, 1);
    check("lh_wait_addr", MemAddr, 32'h100);
    check("lh_wait_done", Done, 0);
    ack_with(32'h7FFF0000);
    check("lh_done", Done, 1);
    check("lh_rdata", ReadData, 32'h00007FFF);
    tick();

    // LH spanning two words
    issue(1'b0, 3'b001, 32'h103, 32'h0);
`ifdef LSU_MISALIGNED_EN
    check("lhs0_addr", MemAddr, 32'h100);
    check("lhs0_be", MemBE, 4'b1000);
    ack_with(32'hAB000000);
    check("lhs1_addr", MemAddr, 32'h104);
    check("lhs1_be", MemBE, 4'b0001);
    ack_with(32'h000000CD);
    check("lhs_done", Done, 1);
    check("lhs_rdata", ReadData, 32'hFFFFCDAB);
`else
    check("lhs_rej_done", Done, 1);
    check("lhs_rej_fault", Fault, 1);
    check("lhs_rej_rdata", ReadData, 32'h00007FFF);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
